// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin sharing of one combinational multiplier among NUM_REQ requesters
module multiplier #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  assign p = (2*W)'(a) * (2*W)'(b);
endmodule

module mult_share_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [2*DATA_WIDTH-1:0]       resp_product
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic [ID_WIDTH-1:0] id_reg, rr_ptr, gnt, idx;
  logic found;
  logic [2*DATA_WIDTH-1:0] prod;
  multiplier #(.W(DATA_WIDTH)) u_mul (.a(op_a), .b(op_b), .p(prod));
  always_comb begin
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end
  assign req_ready = (state == IDLE && found && !rst) ? NUM_REQ'(1) << gnt : '0;
  assign resp_valid = state == DONE;
  always_comb begin
    state_nxt = state == IDLE ? (found ? MUL : IDLE) :
                state == MUL  ? DONE :
                (resp_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      op_a <= '0;
      op_b <= '0;
      id_reg <= '0;
      resp_product <= '0;
      resp_id <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        op_a <= req_a[gnt*DATA_WIDTH +: DATA_WIDTH];
        op_b <= req_b[gnt*DATA_WIDTH +: DATA_WIDTH];
        id_reg <= gnt;
        rr_ptr <= gnt == ID_WIDTH'(NUM_REQ-1) ? '0 : gnt + 1'b1;
      end
      if (state == MUL) begin
        resp_product <= prod;
        resp_id <= id_reg;
      end
    end
  end
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: directed table plus multi-cycle sequences for mult_share_ctrl
module tb_mult_share_ctrl;
  logic clk, rst, resp_valid, resp_ready;
  logic [3:0] req_valid, req_ready;
  logic [15:0] req_a, req_b;
  logic [1:0] resp_id;
  logic [7:0] resp_product;
  int errors = 0, checks = 0;
  typedef struct {
    int r;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;
  vec_t v[7];
  mult_share_ctrl #(.DATA_WIDTH(4), .NUM_REQ(4), .ID_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  initial begin
    int k;
    v[0] = '{1, 4'd15, 4'd15, 8'd225};
    v[1] = '{0, 4'd0, 4'd7, 8'd0};
    v[2] = '{3, 4'd15, 4'd1, 8'd15};
    v[3] = '{2, 4'd9, 4'd13, 8'd117};
    v[4] = '{1, 4'd8, 4'd8, 8'd64};
    v[5] = '{0, 4'd15, 4'd0, 8'd0};
    v[6] = '{3, 4'd12, 4'd11, 8'd132};
    rst = 1'b1;
    resp_ready = 1'b0;
    req_valid = 4'b0101;
    req_a = {4'd0, 4'd2, 4'd0, 4'd3};
    req_b = {4'd0, 4'd7, 4'd0, 4'd5};
    step();
    step();
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_product", 32'(resp_product), 0);
    chk("rst_id", 32'(resp_id), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0100;
    chk("mul_req_ready", 32'(req_ready), 0);
    step();
    chk("post_rst_valid", 32'(resp_valid), 1);
    chk("post_rst_product", 32'(resp_product), 15);
    chk("post_rst_id", 32'(resp_id), 0);
    resp_ready = 1'b1;
    step();
    chk("post_rst_idle", 32'(resp_valid), 0);
    chk("second_grant", 32'(req_ready), 32'h4);
    req_valid = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      req_valid = 4'b0001 << v[i].r;
      req_a[v[i].r*4 +: 4] = v[i].a;
      req_b[v[i].r*4 +: 4] = v[i].b;
      #1;
      chk("vec_grant", 32'(req_ready), 32'(4'b0001 << v[i].r));
      step();
      req_valid = 4'b0000;
      step();
      chk("vec_valid", 32'(resp_valid), 1);
      chk("vec_product", 32'(resp_product), 32'(v[i].p));
      chk("vec_id", 32'(resp_id), 32'(v[i].r));
      step();
      chk("vec_done", 32'(resp_valid), 0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    req_a = {4'd4, 4'd3, 4'd2, 4'd1};
    req_b = {4{4'd3}};
    for (int n = 0; n < 5; n++) begin
      k = 0;
      while (!resp_valid && k < 10) begin
        step();
        k++;
      end
      chk("rr_valid", 32'(resp_valid), 1);
      chk("rr_id", 32'(resp_id), 32'(n % 4));
      chk("rr_product", 32'(resp_product), 32'((n % 4 + 1) * 3));
      step();
    end
    req_valid = 4'b0000;
    resp_ready = 1'b0;
    req_valid = 4'b0100;
    req_a[8 +: 4] = 4'd13;
    req_b[8 +: 4] = 4'd14;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0010;
    step();
    for (int n = 0; n < 5; n++) begin
      chk("bp_valid", 32'(resp_valid), 1);
      chk("bp_product", 32'(resp_product), 182);
      chk("bp_id", 32'(resp_id), 2);
      chk("bp_req_ready", 32'(req_ready), 0);
      step();
    end
    resp_ready = 1'b1;
    step();
    chk("bp_release", 32'(resp_valid), 0);
    chk("bp_next_grant", 32'(req_ready), 32'h2);
    req_valid = 4'b1000;
    #1;
    chk("mid_grant", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b0000;
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(resp_valid), 0);
    chk("mid_rst_product", 32'(resp_product), 0);
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("mid_rst_ptr", 32'(req_ready), 32'h1);
    req_valid = 4'b0000;
    step();
    chk("mid_no_resp0", 32'(resp_valid), 0);
    step();
    chk("mid_no_resp1", 32'(resp_valid), 0);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        resp_ready = 1'b0;
        req_valid = 4'b0010;
        req_a[4 +: 4] = 4'(a);
        req_b[4 +: 4] = 4'(b);
        k = 0;
        #1;
        while (!req_ready[1] && k < 10) begin
          step();
          k++;
        end
        chk("ex_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0000;
        step();
        chk("ex_product", 32'(resp_product), 32'(a * b));
        chk("ex_id", 32'(resp_id), 1);
        k = 0;
        do begin
          resp_ready = 1'($urandom_range(0, 1));
          step();
          k++;
        end while (resp_valid && k < 50);
        chk("ex_drain", 32'(resp_valid), 0);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
